pipeline_sequencer: RTL and testbench

Sequential hazard and stall controller for the 5-stage CPU pipeline. It sits beside the ID-stage decoder and drives the pipeline-register write enables, bubble inserts and PC write enable. It resolves three conditions: load-use hazards, multi-cycle data-memory accesses (ready/request handshake with timeout), and control redirects from taken jumps and branches. It also keeps a saturating stall-cycle counter and a sticky memory-fault flag.

---
 rtl/pipeline_sequencer.sv | 147 ++++++++++++++
 tb/tb_pipeline_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_sequencer.sv
// Hazard/stall controller for the 5-stage pipeline: load-use stalls, multi-cycle
// data-memory waits with timeout, and redirect flushes. Also counts stall cycles.
module pipeline_sequencer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] IFIDInstruction,
   input  logic        IDEXMemRead,
   input  logic [5:0]  IDEXRd,
   input  logic        EXMEMMemRead,
   input  logic        EXMEMMemWrite,
   input  logic        exRedirect,
   input  logic        memReady,
   output logic        memReq,
   output logic        pcWrite,
   output logic        IFIDWrite,
   output logic        IDEXWrite,
   output logic        EXMEMWrite,
   output logic        IFIDFlush,
   output logic        IDEXFlush,
   output logic        MEMWBBubble,
   output logic        memFault,
   output logic [15:0] stallCount
);

   typedef enum logic [1:0] {
      RUN,
      MEMWAIT,
      FAULT
   } stateType;

   localparam logic [8:0] TIMEOUT_LIMIT = 9'(MEM_TIMEOUT);

   stateType   state, nextState;
   logic [7:0] waitCnt, nextWaitCnt;
   logic [8:0] waitInc;
   logic       setFault;

   logic [3:0] opcode;
   logic [5:0] rs, rt;
   logic       usesRs, usesRt, loadUseHazard, accessPending;
   logic       unusedInstrBits;

   assign opcode          = IFIDInstruction[31:28];
   assign rs              = IFIDInstruction[21:16];
   assign rt              = IFIDInstruction[15:10];
   assign unusedInstrBits = ^{IFIDInstruction[27:22], IFIDInstruction[9:0]};
   assign accessPending   = EXMEMMemRead | EXMEMMemWrite;
   assign waitInc         = {1'b0, waitCnt} + 9'd1;

   always_comb begin
      usesRs = 1'b0;
      usesRt = 1'b0;
      case (opcode)
         4'b0011, 4'b0100, 4'b0111: begin
            usesRs = 1'b1;
            usesRt = 1'b1;
         end
         4'b1110, 4'b0101, 4'b0110, 4'b1000,
         4'b1001, 4'b1010, 4'b1011: usesRs = 1'b1;
         default: ;
      endcase
   end

   assign loadUseHazard = IDEXMemRead && (IDEXRd != 6'd0) &&
                          ((usesRs && (rs == IDEXRd)) || (usesRt && (rt == IDEXRd)));

   always_comb begin
      // NOTE: every output and next-state term gets a default first so no path
      // through the case leaves one unassigned, which would infer a latch.
      nextState   = state;
      nextWaitCnt = waitCnt;
      setFault    = 1'b0;
      memReq      = 1'b0;
      pcWrite     = 1'b0;
      IFIDWrite   = 1'b0;
      IDEXWrite   = 1'b0;
      EXMEMWrite  = 1'b0;
      IFIDFlush   = 1'b0;
      IDEXFlush   = 1'b0;
      MEMWBBubble = 1'b0;

      // Outputs are forced low for the whole time reset is asserted.
      if (rst_n) begin
         case (state)
            RUN: begin
               memReq     = accessPending;
               pcWrite    = 1'b1;
               IFIDWrite  = 1'b1;
               IDEXWrite  = 1'b1;
               EXMEMWrite = 1'b1;
               if (accessPending && !memReady) begin
                  pcWrite     = 1'b0;
                  IFIDWrite   = 1'b0;
                  IDEXWrite   = 1'b0;
                  EXMEMWrite  = 1'b0;
                  MEMWBBubble = 1'b1;
                  memReq      = 1'b1;
                  nextState   = MEMWAIT;
               end else if (exRedirect) begin
                  IFIDFlush = 1'b1;
                  IDEXFlush = 1'b1;
               end else if (loadUseHazard) begin
                  pcWrite   = 1'b0;
                  IFIDWrite = 1'b0;
                  IDEXFlush = 1'b1;
               end
            end
            MEMWAIT: begin
               memReq      = 1'b1;
               MEMWBBubble = 1'b1;
               nextWaitCnt = waitInc[7:0];
               if (memReady) begin
                  // Let the completed access retire out of EX/MEM.
                  EXMEMWrite  = 1'b1;
                  MEMWBBubble = 1'b0;
                  nextWaitCnt = 8'd0;
                  nextState   = RUN;
               end else if (waitInc >= TIMEOUT_LIMIT) begin
                  setFault  = 1'b1;
                  nextState = FAULT;
               end
            end
            FAULT:   MEMWBBubble = 1'b1;
            default: nextState = RUN;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RUN;
         waitCnt    <= 8'd0;
         memFault   <= 1'b0;
         stallCount <= 16'd0;
      end else begin
         state   <= nextState;
         waitCnt <= nextWaitCnt;
         if (setFault) memFault <= 1'b1;
         if (!pcWrite && (stallCount != 16'hFFFF)) stallCount <= stallCount + 16'd1;
      end
   end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed test-plan scenarios plus
// randomized traffic, all compared against a behavioural model.
module tb_pipeline_sequencer;

   localparam int MEM_TIMEOUT = 15;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] IFIDInstruction;
   logic        IDEXMemRead;
   logic [5:0]  IDEXRd;
   logic        EXMEMMemRead, EXMEMMemWrite, exRedirect, memReady;
   logic        memReq, pcWrite, IFIDWrite, IDEXWrite, EXMEMWrite;
   logic        IFIDFlush, IDEXFlush, MEMWBBubble, memFault;
   logic [15:0] stallCount;

   typedef struct packed {
      logic memReq, pcWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IFIDFlush, IDEXFlush, MEMWBBubble;
   } ctrlType;

   pipeline_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .IFIDInstruction(IFIDInstruction),
      .IDEXMemRead(IDEXMemRead), .IDEXRd(IDEXRd), .EXMEMMemRead(EXMEMMemRead),
      .EXMEMMemWrite(EXMEMMemWrite), .exRedirect(exRedirect), .memReady(memReady),
      .memReq(memReq), .pcWrite(pcWrite), .IFIDWrite(IFIDWrite), .IDEXWrite(IDEXWrite),
      .EXMEMWrite(EXMEMWrite), .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush),
      .MEMWBBubble(MEMWBBubble), .memFault(memFault), .stallCount(stallCount)
   );

   always #5 clk = ~clk;

   int checkCount = 0;
   int passCount  = 0;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
   endtask

   // Behavioural model: a pending memory access, how long it has waited,
   // whether the block has faulted, and the total of stalled cycles.
   bit mWaiting, mFaulted;
   int mWaitCycles, mStalls;

   function automatic bit readsReg(input logic [31:0] instr, input logic [5:0] r);
      logic [3:0] opc;
      bit rsUsed, rtUsed;
      opc    = instr[31:28];
      rsUsed = opc inside {4'hE, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB};
      rtUsed = opc inside {4'h3, 4'h4, 4'h7};
      return (rsUsed && instr[21:16] == r) || (rtUsed && instr[15:10] == r);
   endfunction

   function automatic logic [31:0] mkInstr(input logic [3:0] opc, input logic [5:0] rs, input logic [5:0] rt);
      return {opc, 6'(($urandom)), rs, rt, 10'($urandom)};
   endfunction

   // One clock cycle: predict, compare mid-cycle, then advance the model.
   task automatic cycle();
      ctrlType exp, obs;
      bit nWaiting, nFaulted, pending, hazard;
      int nWaitCycles;
      if (!rst_n) begin
         mWaiting = 0; mFaulted = 0; mWaitCycles = 0; mStalls = 0;
      end
      nWaiting    = mWaiting;
      nFaulted    = mFaulted;
      nWaitCycles = mWaitCycles;
      pending     = EXMEMMemRead || EXMEMMemWrite;
      hazard      = IDEXMemRead && IDEXRd != 0 && readsRg(IFIDInstruction, IDEXRd);
      exp = '0;
      if (!rst_n) begin
         exp = '0;
      end else if (mFaulted) begin
         exp.MEMWBBubble = 1;
      end else if (mWaiting || (pending && !memReady)) begin
         exp.memReq = 1;
         exp.MEMWBBubble = 1;
         if (!mWaiting) begin
            nWaiting = 1;
         end else if (memReady) begin
            exp.EXMEMWrite = 1;
            exp.MEMWBBubble = 0;
            nWaiting = 0;
            nWaitCycles = 0;
         end else begin
            nWaitCycles = mWaitCycles + 1;
            if (nWaitCycles == MEM_TIMEOUT) nFaulted = 1;
         end
      end else begin
         exp = '{memReq: pending, pcWrite: 1, IFIDWrite: 1, IDEXWrite: 1, EXMEMWrite: 1,
                 IFIDFlush: 0, IDEXFlush: 0, MEMWBBubble: 0};
         if (exRedirect) begin
            exp.IFIDFlush = 1;
            exp.IDEXFlush = 1;
         end else if (hazard) begin
            exp.pcWrite = 0;
            exp.IFIDWrite = 0;
            exp.IDEXFlush = 1;
         end
      end
      @(negedge clk);
      obs = '{memReq, pcWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IFIDFlush, IDEXFlush, MEMWBBubble};
      check("ctrl", 32'(obs), 32'(exp));
      check("stallCount", 32'(stallCount), 32'(mStalls));
      check("memFault", 32'(memFault), 32'(mFaulted));
      @(posedge clk);
      #1;
      if (rst_n) begin
         mWaiting = nWaiting; mFaulted = nFaulted; mWaitCycles = nWaitCycles;
         if (!exp.pcWrite && mStalls < 65535) mStalls++;
      end
   endtask

   function automatic bit readsRg(input logic [31:0] instr, input logic [5:0] r);
      return readsReg(instr, r);
   endfunction

   task automatic idle();
      IFIDInstruction = 32'd0; IDEXMemRead = 0; IDEXRd = 6'd0;
      EXMEMMemRead = 0; EXMEMMemWrite = 0; exRedirect = 0; memReady = 0;
   endtask

   task automatic doReset();
      idle();
      rst_n = 0;
      cycle();
      rst_n = 1;
   endtask

   initial begin
      idle();
      rst_n = 0;
      cycle();
      rst_n = 1;
      cycle();

      // Load-use: LD r5 in ID/EX, ADD reading r5 in IF/ID.
      IDEXMemRead = 1; IDEXRd = 6'd5; IFIDInstruction = mkInstr(4'h4, 6'd5, 6'd9);
      cycle();
      IDEXMemRead = 0; EXMEMMemRead = 1; memReady = 1;
      cycle();
      check("loadUseStalls", 32'(stallCount), 32'd1);

      // No-stall variants.
      EXMEMMemRead = 0; memReady = 0;
      IDEXMemRead = 1; IDEXRd = 6'd0; IFIDInstruction = mkInstr(4'h4, 6'd0, 6'd0);
      cycle();
      IDEXRd = 6'd5; IFIDInstruction = mkInstr(4'hF, 6'd5, 6'd5);
      cycle();
      IFIDInstruction = mkInstr(4'h6, 6'd1, 6'd5);
      cycle();
      check("noStallCount", 32'(stallCount), 32'd1);

      // Redirect overrides a load-use hazard.
      IFIDInstruction = mkInstr(4'h7, 6'd2, 6'd5); exRedirect = 1;
      cycle();
      check("redirectNoStall", 32'(stallCount), 32'd1);

      // Memory wait of 3 cycles while a redirect is pending.
      doReset();
      EXMEMMemRead = 1; exRedirect = 1;
      repeat (3) cycle();
      memReady = 1;
      cycle();
      EXMEMMemRead = 0; memReady = 0;
      cycle();
      check("memWaitStalls", 32'(stallCount), 32'd4);

      // Timeout into FAULT, then reset recovery.
      doReset();
      EXMEMMemWrite = 1;
      repeat (1 + MEM_TIMEOUT) cycle();
      check("faultFlag", 32'(memFault), 32'd1);
      repeat (3) cycle();
      rst_n = 0;
      cycle();
      rst_n = 1; idle();
      cycle();
      check("afterResetStalls", 32'(stallCount), 32'd0);

      // Randomized traffic; some epochs make memReady rare to reach timeouts.
      for (int epoch = 0; epoch < 8; epoch++) begin
         int readyPct;
         readyPct = (epoch % 2 == 1) ? 3 : 50;
         doReset();
         for (int i = 0; i < 300; i++) begin
            IDEXMemRead     = ($urandom_range(0, 1) == 1);
            IDEXRd          = 6'($urandom_range(0, 3));
            IFIDInstruction = mkInstr(4'($urandom), 6'($urandom_range(0, 3)), 6'($urandom_range(0, 3)));
            EXMEMMemRead    = ($urandom_range(0, 99) < 30);
            EXMEMMemWrite   = ($urandom_range(0, 99) < 15);
            exRedirect      = ($urandom_range(0, 99) < 20);
            memReady        = ($urandom_range(0, 99) < readyPct);
            rst_n           = ($urandom_range(0, 199) != 0);
            cycle();
         end
         rst_n = 1;
      end

      // Saturation: park in FAULT long enough to overflow the counter.
      doReset();
      EXMEMMemRead = 1;
      repeat (70000) cycle();
      check("stallSaturate", 32'(stallCount), 32'h0000_FFFF);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
